mem_arbiter: RTL

Two-requester arbiter and sequencer in front of memunit (the SDRAM front-end). It shares the single memunit command port between an instruction-fetch requester (port A) and a data load/store requester (port B). It drives memunit's enable/rwn/memaddr/data_in handshake, routes data_out/data_valid back to the granted requester, and reports completion or timeout per port.

---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer for memunit.
// Port A is instruction fetch, port B is data load/store.
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              a_req,
   input  logic              a_rwn,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   output logic              a_done,
   output logic              a_err,
   input  logic              b_req,
   input  logic              b_rwn,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid,
   output logic              b_done,
   output logic              b_err,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic              mem_data_valid,
   output logic              mem_enable,
   output logic              mem_rwn,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pick;
   logic              expired;
   logic              fin, fin_err;

   logic              en_d, rwn_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic [DATA_W-1:0] a_rdata_d, b_rdata_d;
   logic              a_rvalid_d, b_rvalid_d;
   logic              a_done_d, b_done_d;
   logic              a_err_d, b_err_d;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      pick = PORT_A;
      unique case (1'b1)
         (a_req && !b_req): pick = PORT_A;
         (!a_req && b_req): pick = PORT_B;
         (a_req && b_req):  pick = ~last_q;
         default:           pick = PORT_A;
      endcase
   end

   assign expired = (cnt_q == CNT_MAX);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      en_d       = mem_enable;
      rwn_d      = mem_rwn;
      addr_d     = mem_addr;
      wdata_d    = mem_data_in;
      a_rdata_d  = a_rdata;
      b_rdata_d  = b_rdata;
      a_rvalid_d = 1'b0;
      b_rvalid_d = 1'b0;
      fin        = 1'b0;
      fin_err    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (mem_ready && (a_req || b_req)) begin
               grant_d = pick;
               rwn_d   = pick ? b_rwn   : a_rwn;
               addr_d  = pick ? b_addr  : a_addr;
               wdata_d = pick ? b_wdata : a_wdata;
               en_d    = 1'b1;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (expired) begin
               en_d    = 1'b0;
               fin     = 1'b1;
               fin_err = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (!mem_ready) begin
                  en_d    = 1'b0;
                  state_d = WAIT_DONE;
               end
            end
         end
         WAIT_DONE: begin
            if (mem_data_valid) begin
               if (grant_q == PORT_B) begin
                  b_rdata_d  = mem_data_out;
                  b_rvalid_d = 1'b1;
               end else begin
                  a_rdata_d  = mem_data_out;
                  a_rvalid_d = 1'b1;
               end
            end
            if (expired) begin
               fin     = 1'b1;
               fin_err = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (mem_ready) begin
                  fin     = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      a_done_d = fin && (grant_q == PORT_A);
      b_done_d = fin && (grant_q == PORT_B);
      a_err_d  = fin_err && (grant_q == PORT_A);
      b_err_d  = fin_err && (grant_q == PORT_B);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= IDLE;
         grant_q     <= PORT_A;
         last_q      <= PORT_B;
         cnt_q       <= '0;
         mem_enable  <= 1'b0;
         mem_rwn     <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         a_rdata     <= '0;
         b_rdata     <= '0;
         a_rvalid    <= 1'b0;
         b_rvalid    <= 1'b0;
         a_done      <= 1'b0;
         b_done      <= 1'b0;
         a_err       <= 1'b0;
         b_err       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         mem_enable  <= en_d;
         mem_rwn     <= rwn_d;
         mem_addr    <= addr_d;
         mem_data_in <= wdata_d;
         a_rdata     <= a_rdata_d;
         b_rdata     <= b_rdata_d;
         a_rvalid    <= a_rvalid_d;
         b_rvalid    <= b_rvalid_d;
         a_done      <= a_done_d;
         b_done      <= b_done_d;
         a_err       <= a_err_d;
         b_err       <= b_err_d;
      end
   end

endmodule
